// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    FAULT = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The reserved size encoding is reported as a misalignment fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store data replication and load lane extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wd,
  input  logic [31:0] rd,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    store_data = wd;
    case (size)
      SZ_BYTE: store_data = {4{wd[7:0]}};
      SZ_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  end

  always_comb begin
    lane_byte = rd[7:0];
    case (byte_off)
      2'd0:    lane_byte = rd[7:0];
      2'd1:    lane_byte = rd[15:8];
      2'd2:    lane_byte = rd[23:16];
      default: lane_byte = rd[31:24];
    endcase
  end

  assign lane_half = byte_off[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    load_data = rd;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = is_unsigned ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = rd;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding bus transfer, misalignment faults, load extension.
// Define LSU_RDATA_REG_EN to register the result one cycle after data_done.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_w_rb,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wd,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        lsu_misalign,
  output logic        data_req,
  output logic        data_w_rb,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wd,
  input  logic [31:0] data_rd,
  input  logic        data_done,
  input  logic        data_err
);

  lsu_state_t  state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        w_rb_q;
  logic        uns_q;
  logic [31:0] wd_q;
  logic        ready_q;
  logic        req_q;
  logic        fault_q;
  logic [31:0] bus_addr_q;
  logic [1:0]  bus_size_q;
  logic        bus_w_rb_q;
  logic [31:0] bus_wd_q;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        accept;
  logic        misaligned;
  logic        done_now;

  assign accept     = lsu_valid & ready_q;
  assign misaligned = is_misaligned(lsu_size, lsu_addr[1:0]);
  assign done_now   = (state == DATA) & data_done;

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .byte_off    (off_q),
    .wd          (wd_q),
    .rd          (data_rd),
    .store_data  (store_data),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      size_q     <= '0;
      off_q      <= '0;
      w_rb_q     <= 1'b0;
      uns_q      <= 1'b0;
      wd_q       <= '0;
      ready_q    <= 1'b1;
      req_q      <= 1'b0;
      fault_q    <= 1'b0;
      bus_addr_q <= '0;
      bus_size_q <= '0;
      bus_w_rb_q <= 1'b0;
      bus_wd_q   <= '0;
    end else begin
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            size_q  <= lsu_size;
            off_q   <= lsu_addr[1:0];
            w_rb_q  <= lsu_w_rb;
            uns_q   <= lsu_unsigned;
            wd_q    <= lsu_wd;
            ready_q <= 1'b0;
            if (misaligned) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state      <= ADDR;
              req_q      <= 1'b1;
              bus_addr_q <= lsu_addr;
              bus_size_q <= lsu_size;
              bus_w_rb_q <= lsu_w_rb;
            end
          end
        end
        ADDR: begin
          // Store data goes out on the lanes during DATA only; loads drive zero.
          state    <= DATA;
          bus_wd_q <= w_rb_q ? store_data : '0;
        end
        DATA: begin
          if (data_done) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            bus_addr_q <= '0;
            bus_size_q <= '0;
            bus_w_rb_q <= 1'b0;
            bus_wd_q   <= '0;
          end
        end
        FAULT: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign lsu_ready    = ready_q;
  assign data_req     = req_q;
  assign data_addr    = bus_addr_q;
  assign data_size    = bus_size_q;
  assign data_w_rb    = bus_w_rb_q;
  assign data_wd      = bus_wd_q;
  assign lsu_misalign = fault_q;

`ifdef LSU_RDATA_REG_EN
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= done_now;
      err_q    <= done_now & data_err;
      rdata_q  <= (done_now & ~data_err & ~w_rb_q) ? load_data : '0;
    end
  end

  assign lsu_rvalid = fault_q | rvalid_q;
  assign lsu_err    = err_q;
  assign lsu_rdata  = rdata_q;
`else
  assign lsu_rvalid = fault_q | done_now;
  assign lsu_err    = done_now & data_err;
  assign lsu_rdata  = (done_now & ~data_err & ~w_rb_q) ? load_data : '0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu; adapts result timing to LSU_RDATA_REG_EN.
module tb_lsu;

  logic        clk;
  logic        rstn;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_w_rb;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wd;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        lsu_misalign;
  logic        data_req;
  logic        data_w_rb;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wd;
  logic [31:0] data_rd;
  logic        data_done;
  logic        data_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  lsu dut (
    .clk          (clk),
    .rstn         (rstn),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_w_rb     (lsu_w_rb),
    .lsu_size     (lsu_size),
    .lsu_unsigned (lsu_unsigned),
    .lsu_addr     (lsu_addr),
    .lsu_wd       (lsu_wd),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_rdata    (lsu_rdata),
    .lsu_err      (lsu_err),
    .lsu_misalign (lsu_misalign),
    .data_req     (data_req),
    .data_w_rb    (data_w_rb),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wd      (data_wd),
    .data_rd      (data_rd),
    .data_done    (data_done),
    .data_err     (data_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic popResult(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("[TB] FAIL %s: result observed but scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, " rvalid"}, {31'd0, lsu_rvalid}, 32'd1);
      checkOutput({tag, " rdata"}, lsu_rdata, e.rdata);
      checkOutput({tag, " err"}, {31'd0, lsu_err}, {31'd0, e.err});
      checkOutput({tag, " misalign"}, {31'd0, lsu_misalign}, {31'd0, e.mis});
    end
  endtask

  // One aligned transfer; called just after a falling edge.
  task automatic applyStimulus(input string tag, input logic w_rb, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input logic err, input int delay,
                               input logic [31:0] exp_wd, input logic [31:0] exp_rdata);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = err;
    e.mis   = 1'b0;
    exp_q.push_back(e);
    lsu_valid    = 1'b1;
    lsu_w_rb     = w_rb;
    lsu_size     = size;
    lsu_unsigned = uns;
    lsu_addr     = addr;
    lsu_wd       = wd;
    @(negedge clk);
    checkOutput({tag, " addr req"}, {31'd0, data_req}, 32'd1);
    checkOutput({tag, " addr data_addr"}, data_addr, addr);
    checkOutput({tag, " addr data_size"}, {30'd0, data_size}, {30'd0, size});
    checkOutput({tag, " addr data_w_rb"}, {31'd0, data_w_rb}, {31'd0, w_rb});
    checkOutput({tag, " addr data_wd"}, data_wd, 32'd0);
    checkOutput({tag, " addr ready"}, {31'd0, lsu_ready}, 32'd0);
    lsu_valid = 1'b0;
    lsu_wd    = 32'd0;
    @(negedge clk);
    checkOutput({tag, " data req"}, {31'd0, data_req}, 32'd0);
    checkOutput({tag, " data data_wd"}, data_wd, exp_wd);
    for (int i = 0; i < delay; i++) begin
      checkOutput({tag, " wait ready"}, {31'd0, lsu_ready}, 32'd0);
      checkOutput({tag, " wait rvalid"}, {31'd0, lsu_rvalid}, 32'd0);
      @(negedge clk);
    end
    checkOutput({tag, " held data_wd"}, data_wd, exp_wd);
    data_done = 1'b1;
    data_rd   = rd;
    data_err  = err;
    #1;
`ifdef LSU_RDATA_REG_EN
    checkOutput({tag, " early rvalid"}, {31'd0, lsu_rvalid}, 32'd0);
`else
    popResult(tag);
`endif
    @(negedge clk);
    data_done = 1'b0;
    data_rd   = 32'd0;
    data_err  = 1'b0;
    #1;
`ifdef LSU_RDATA_REG_EN
    popResult(tag);
`else
    checkOutput({tag, " late rvalid"}, {31'd0, lsu_rvalid}, 32'd0);
`endif
    checkOutput({tag, " idle ready"}, {31'd0, lsu_ready}, 32'd1);
  endtask

  task automatic applyMisaligned(input string tag, input logic [1:0] size, input logic [31:0] addr);
    exp_t e;
    e.rdata = 32'd0;
    e.err   = 1'b0;
    e.mis   = 1'b1;
    exp_q.push_back(e);
    lsu_valid    = 1'b1;
    lsu_w_rb     = 1'b0;
    lsu_size     = size;
    lsu_unsigned = 1'b0;
    lsu_addr     = addr;
    @(negedge clk);
    lsu_valid = 1'b0;
    checkOutput({tag, " req"}, {31'd0, data_req}, 32'd0);
    checkOutput({tag, " ready"}, {31'd0, lsu_ready}, 32'd0);
    popResult(tag);
    @(negedge clk);
    checkOutput({tag, " ready after"}, {31'd0, lsu_ready}, 32'd1);
    checkOutput({tag, " rvalid after"}, {31'd0, lsu_rvalid}, 32'd0);
    checkOutput({tag, " misalign after"}, {31'd0, lsu_misalign}, 32'd0);
    checkOutput({tag, " req after"}, {31'd0, data_req}, 32'd0);
  endtask

  initial begin
    rstn         = 1'b0;
    lsu_valid    = 1'b0;
    lsu_w_rb     = 1'b0;
    lsu_size     = 2'b00;
    lsu_unsigned = 1'b0;
    lsu_addr     = 32'd0;
    lsu_wd       = 32'd0;
    data_rd      = 32'd0;
    data_done    = 1'b0;
    data_err     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", {31'd0, lsu_ready}, 32'd1);
    checkOutput("reset rvalid", {31'd0, lsu_rvalid}, 32'd0);
    checkOutput("reset err", {31'd0, lsu_err}, 32'd0);
    checkOutput("reset misalign", {31'd0, lsu_misalign}, 32'd0);
    checkOutput("reset rdata", lsu_rdata, 32'd0);
    checkOutput("reset req", {31'd0, data_req}, 32'd0);
    checkOutput("reset data_addr", data_addr, 32'd0);
    checkOutput("reset data_wd", data_wd, 32'd0);
    checkOutput("reset data_size", {30'd0, data_size}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    applyStimulus("sw deadbeef", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0, 32'hDEADBEEF, 32'h0);
    applyStimulus("lb signed", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 1'b0, 0, 32'h0, 32'hFFFFFF80);
    applyStimulus("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 1'b0, 0, 32'h0, 32'h00000080);
    applyStimulus("lh wait", 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'h7FFF0000, 1'b0, 5, 32'h0, 32'h00007FFF);
    applyMisaligned("lw misalign", 2'b10, 32'h6);
    applyStimulus("lw err", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h12345678, 1'b1, 1, 32'h0, 32'h0);
    applyStimulus("sb lanes", 1'b1, 2'b00, 1'b0, 32'h201, 32'h123456A5, 32'h0, 1'b0, 2, 32'hA5A5A5A5, 32'h0);
    applyStimulus("sh lanes", 1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFFBEEF, 32'h0, 1'b0, 0, 32'hBEEFBEEF, 32'h0);
    applyStimulus("lh low signed", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h12348001, 1'b0, 0, 32'h0, 32'hFFFF8001);
    applyStimulus("lb lane1 unsigned", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000C300, 1'b0, 0, 32'h0, 32'h000000C3);
    applyMisaligned("lh odd", 2'b01, 32'h1);
    applyMisaligned("size reserved", 2'b11, 32'h0);

    // Stray done while idle must not complete anything.
    data_done = 1'b1;
    #1;
    checkOutput("idle stray rvalid", {31'd0, lsu_rvalid}, 32'd0);
    @(negedge clk);
    data_done = 1'b0;
    checkOutput("idle stray ready", {31'd0, lsu_ready}, 32'd1);

    // Reset while a load is waiting in DATA.
    lsu_valid = 1'b1;
    lsu_w_rb  = 1'b0;
    lsu_size  = 2'b10;
    lsu_addr  = 32'h20;
    @(negedge clk);
    lsu_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst mid ready", {31'd0, lsu_ready}, 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("rst mid ready after", {31'd0, lsu_ready}, 32'd1);
    checkOutput("rst mid req", {31'd0, data_req}, 32'd0);
    checkOutput("rst mid data_addr", data_addr, 32'd0);
    data_done = 1'b1;
    data_rd   = 32'hFFFFFFFF;
    #1;
    checkOutput("rst stray rvalid", {31'd0, lsu_rvalid}, 32'd0);
    @(negedge clk);
    data_done = 1'b0;
    data_rd   = 32'd0;
    checkOutput("rst stray rvalid late", {31'd0, lsu_rvalid}, 32'd0);

    applyStimulus("lw after reset", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 0, 32'h0, 32'hCAFEF00D);

    checkOutput("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
